packet_gen_axis: RTL and testbench

- Parametrised AXI-Stream Ethernet frame generator, successor to the single-width command-driven frame builder.
- Pops frame commands from a first-word-fall-through (FWFT) command FIFO: size, MACs, ethertype, payload seed, payload mode.
- Emits the frame on AXI-Stream for any supported DATA_WIDTH, with the 14-byte header spanning as many beats as needed.
- Honours tready backpressure, inserts a programmable inter-frame gap and counts completed frames.

---
 rtl/packet_gen_axis.sv | 185 ++++++++++++++++++
 tb/tb_packet_gen_axis.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_gen_axis.sv
// packet_gen_axis
//   AXI-Stream Ethernet frame generator. Pops frame commands from a
//   first-word-fall-through command FIFO and emits each frame as a 14-byte
//   header {ethertype, s_mac, d_mac} (d_mac[7:0] first) followed by a payload
//   that is either a constant fill or an incrementing byte sequence.
//   Bytes are packed little-endian into DATA_WIDTH-bit beats. The last beat
//   carries a partial tkeep, and bytes outside tkeep are driven to zero.
//
// Parameters
//   DATA_WIDTH  stream width in bits (64, 128, 256, 512)
//   IFG_CYCLES  tvalid-low cycles between frames when commands are waiting (0-15)
//   MIN_SIZE    minimum frame length in bytes (>= 14)
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   fifo_rd_valid        command FIFO head valid (FWFT)
//   fifo_rd_enable       pop request; a command is consumed when valid && enable
//   size .. payload_mode command fields at the FIFO head
//   axis_t*              AXI-Stream master (registered)
//   frame_count          completed frames, wraps at 2^32
//   busy                 high whenever the generator is not idle
module packet_gen_axis #(
   parameter int DATA_WIDTH = 64,
   parameter int IFG_CYCLES = 0,
   parameter int MIN_SIZE   = 14
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    fifo_rd_valid,
   output logic                    fifo_rd_enable,
   input  logic [10:0]             size,
   input  logic [47:0]             d_mac,
   input  logic [47:0]             s_mac,
   input  logic [15:0]             ethertype,
   input  logic [7:0]              payload,
   input  logic                    payload_mode,
   output logic [DATA_WIDTH-1:0]   axis_tdata,
   output logic [DATA_WIDTH/8-1:0] axis_tkeep,
   output logic                    axis_tvalid,
   input  logic                    axis_tready,
   output logic                    axis_tlast,
   output logic [31:0]             frame_count,
   output logic                    busy
);

   localparam int          N        = DATA_WIDTH / 8;
   localparam logic [11:0] STEP     = 12'(N);
   localparam logic [10:0] MIN_LEN  = 11'(MIN_SIZE);
   localparam bit          ZERO_GAP = (IFG_CYCLES == 0);
   localparam bit          USE_GAP  = (IFG_CYCLES >= 2);
   // The IDLE cycle in which the next command is popped is itself one of the
   // inter-frame cycles, so GAP only has to cover the remaining IFG_CYCLES-1.
   localparam logic [3:0]  GAP_LOAD = 4'((IFG_CYCLES >= 2) ? IFG_CYCLES - 2 : 0);

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

   typedef struct packed {
      logic [10:0]  len;    // already raised to MIN_LEN
      logic [111:0] hdr;    // {ethertype, s_mac, d_mac}, byte 0 in [7:0]
      logic [7:0]   seed;
      logic         mode;
   } cmd_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [N-1:0]          keep;
      logic                  last;
   } beat_t;

   state_t      state;
   cmd_t        cmd_q;
   cmd_t        cmd_in;
   logic [11:0] byte_offset;   // first frame byte of the beat on the bus
   logic [11:0] next_offset;
   logic [3:0]  gap_cnt;
   beat_t       first_beat;
   beat_t       next_beat;
   logic        pop;

   // Builds the beat starting at frame byte 'off'. 12-bit offsets cannot
   // overflow for frames up to 2047 bytes plus one beat of lookahead.
   function automatic beat_t build_beat(input cmd_t c, input logic [11:0] off);
      beat_t       r;
      logic [11:0] k;
      logic [7:0]  b;
      r = '0;
      for (int j = 0; j < N; j++) begin
         k = off + 12'(j);
         b = 8'h00;
         if (k < {1'b0, c.len}) begin
            if (k < 12'd14)
               b = 8'(c.hdr >> {k[3:0], 3'b000});
            else if (c.mode)
               b = c.seed + k[7:0] - 8'd14;
            else
               b = c.seed;
            r.data[8*j +: 8] = b;
            r.keep[j]        = 1'b1;
         end
      end
      r.last = (off + STEP) >= {1'b0, c.len};
      return r;
   endfunction

   // NOTE: every always_comb target gets a value on every path, so no latch is inferred.
   always_comb begin
      cmd_in.len  = (size < MIN_LEN) ? MIN_LEN : size;
      cmd_in.hdr  = {ethertype, s_mac, d_mac};
      cmd_in.seed = payload;
      cmd_in.mode = payload_mode;
      next_offset = byte_offset + STEP;
      first_beat  = build_beat(cmd_in, 12'd0);
      next_beat   = build_beat(cmd_q, next_offset);
   end

   // With no gap the next command may be popped while the last beat handshakes,
   // so frames run back to back without a bubble.
   assign fifo_rd_enable = !rst && ((state == IDLE) ||
                                    (ZERO_GAP && state == SEND && axis_tvalid &&
                                     axis_tready && axis_tlast));
   assign pop  = fifo_rd_valid && fifo_rd_enable;
   assign busy = (state != IDLE);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cmd_q       <= '0;
         byte_offset <= '0;
         gap_cnt     <= '0;
         axis_tvalid <= 1'b0;
         axis_tlast  <= 1'b0;
         axis_tdata  <= '0;
         axis_tkeep  <= '0;
         frame_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  cmd_q                               <= cmd_in;
                  byte_offset                         <= '0;
                  {axis_tdata, axis_tkeep, axis_tlast} <= first_beat;
                  axis_tvalid                         <= 1'b1;
                  state                               <= SEND;
               end
            end
            SEND: begin
               // tvalid is always high in SEND; a stall simply holds every output.
               if (axis_tready) begin
                  if (axis_tlast) begin
                     frame_count <= frame_count + 32'd1;
                     if (pop) begin
                        cmd_q                               <= cmd_in;
                        byte_offset                         <= '0;
                        {axis_tdata, axis_tkeep, axis_tlast} <= first_beat;
                     end else begin
                        axis_tvalid <= 1'b0;
                        axis_tlast  <= 1'b0;
                        axis_tdata  <= '0;
                        axis_tkeep  <= '0;
                        if (USE_GAP) begin
                           gap_cnt <= GAP_LOAD;
                           state   <= GAP;
                        end else begin
                           state <= IDLE;
                        end
                     end
                  end else begin
                     byte_offset                         <= next_offset;
                     {axis_tdata, axis_tkeep, axis_tlast} <= next_beat;
                  end
               end
            end
            GAP: begin
               if (gap_cnt == 4'd0)
                  state <= IDLE;
               else
                  gap_cnt <= gap_cnt - 4'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_packet_gen_axis.sv
// tb_packet_gen_axis
//   Drives two generators side by side (64-bit with no inter-frame gap and
//   128-bit with a 3-cycle gap) from per-instance command queues. A byte-level
//   frame model turns every popped command into its expected beats, and one
//   monitor compares the stream, frame counter and gap timing each cycle.
module tb_packet_gen_axis;

   typedef struct packed {
      logic [10:0] size;
      logic [47:0] d_mac;
      logic [47:0] s_mac;
      logic [15:0] et;
      logic [7:0]  seed;
      logic        mode;
   } cmd_t;

   typedef struct packed {
      logic [127:0] data;
      logic [15:0]  keep;
      logic         last;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic [1:0]        fifo_rd_valid;
   logic [1:0]        fifo_rd_enable;
   logic [1:0][10:0]  size_i;
   logic [1:0][47:0]  d_mac_i;
   logic [1:0][47:0]  s_mac_i;
   logic [1:0][15:0]  et_i;
   logic [1:0][7:0]   pl_i;
   logic [1:0]        mode_i;
   logic [63:0]       tdata_a;
   logic [7:0]        tkeep_a;
   logic [127:0]      tdata_b;
   logic [15:0]       tkeep_b;
   logic [1:0][127:0] tdata_w;
   logic [1:0][15:0]  tkeep_w;
   logic [1:0]        tvalid;
   logic [1:0]        tready;
   logic [1:0]        tlast;
   logic [1:0][31:0]  fcnt;
   logic [1:0]        busy;

   assign tdata_w[0] = {64'h0, tdata_a};
   assign tdata_w[1] = tdata_b;
   assign tkeep_w[0] = {8'h0, tkeep_a};
   assign tkeep_w[1] = tkeep_b;

   always #5 clk = ~clk;

   packet_gen_axis #(.DATA_WIDTH(64), .IFG_CYCLES(0), .MIN_SIZE(14)) u_w64 (
      .clk(clk), .rst(rst),
      .fifo_rd_valid(fifo_rd_valid[0]), .fifo_rd_enable(fifo_rd_enable[0]),
      .size(size_i[0]), .d_mac(d_mac_i[0]), .s_mac(s_mac_i[0]),
      .ethertype(et_i[0]), .payload(pl_i[0]), .payload_mode(mode_i[0]),
      .axis_tdata(tdata_a), .axis_tkeep(tkeep_a), .axis_tvalid(tvalid[0]),
      .axis_tready(tready[0]), .axis_tlast(tlast[0]),
      .frame_count(fcnt[0]), .busy(busy[0])
   );

   packet_gen_axis #(.DATA_WIDTH(128), .IFG_CYCLES(3), .MIN_SIZE(14)) u_w128 (
      .clk(clk), .rst(rst),
      .fifo_rd_valid(fifo_rd_valid[1]), .fifo_rd_enable(fifo_rd_enable[1]),
      .size(size_i[1]), .d_mac(d_mac_i[1]), .s_mac(s_mac_i[1]),
      .ethertype(et_i[1]), .payload(pl_i[1]), .payload_mode(mode_i[1]),
      .axis_tdata(tdata_b), .axis_tkeep(tkeep_b), .axis_tvalid(tvalid[1]),
      .axis_tready(tready[1]), .axis_tlast(tlast[1]),
      .frame_count(fcnt[1]), .busy(busy[1])
   );

   // ---------------------------------------------------------------- bookkeeping
   int checks   = 0;
   int failures = 0;

   cmd_t  cmdq[2][$];
   beat_t expq[2][$];

   logic [31:0] mcnt[2];
   logic        pop_pend[2];
   logic        popped_prev[2];
   logic        prev_stall[2];
   beat_t       prev_beat[2];
   logic        in_gap[2];
   logic        gap_ok[2];
   int          gap_len[2];
   int          tr_mode     = 0;   // 0: always ready, 1: 1,0,0,1 pattern, 2: random
   logic        valid_gaps  = 1'b0;
   int          tr_phase[2] = '{0, 0};

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
      end
   endtask

   function automatic string nm(input int d, input string s);
      return $sformatf("%s.%s", (d == 0) ? "w64" : "w128", s);
   endfunction

   function automatic int nbytes(input int d);
      return (d == 0) ? 8 : 16;
   endfunction

   function automatic int ifg(input int d);
      return (d == 0) ? 0 : 3;
   endfunction

   // ---------------------------------------------------------------- frame model
   function automatic int frame_len(input cmd_t c);
      return (int'(c.size) < 14) ? 14 : int'(c.size);
   endfunction

   function automatic logic [7:0] frame_byte(input cmd_t c, input int k);
      logic [111:0] hdr;
      hdr = {c.et, c.s_mac, c.d_mac};
      if (k < 14) return hdr[8*k +: 8];
      if (!c.mode) return c.seed;
      return 8'((int'(c.seed) + k - 14) % 256);
   endfunction

   function automatic beat_t model_beat(input cmd_t c, input int n, input int b);
      beat_t e;
      int    len;
      int    beats;
      len   = frame_len(c);
      beats = (len + n - 1) / n;
      e     = '0;
      for (int j = 0; j < n; j++) begin
         if (b * n + j < len) begin
            e.data[8*j +: 8] = frame_byte(c, b * n + j);
            e.keep[j]        = 1'b1;
         end
      end
      e.last = (b == beats - 1);
      return e;
   endfunction

   task automatic expect_frame(input int d, input cmd_t c);
      int n;
      int beats;
      n     = nbytes(d);
      beats = (frame_len(c) + n - 1) / n;
      for (int b = 0; b < beats; b++) expq[d].push_back(model_beat(c, n, b));
   endtask

   function automatic cmd_t mk_cmd(input logic [10:0] sz, input logic [7:0] seed, input logic mode);
      cmd_t c;
      c.size  = sz;
      c.d_mac = 48'h112233445566;
      c.s_mac = 48'hAABBCCDDEEFF;
      c.et    = 16'h0800;
      c.seed  = seed;
      c.mode  = mode;
      return c;
   endfunction

   function automatic cmd_t rand_cmd();
      cmd_t c;
      c.size  = ($urandom_range(7) == 0) ? 11'($urandom_range(2047)) : 11'($urandom_range(200));
      c.d_mac = {16'($urandom), $urandom};
      c.s_mac = {16'($urandom), $urandom};
      c.et    = 16'($urandom);
      c.seed  = 8'($urandom);
      c.mode  = 1'($urandom);
      return c;
   endfunction

   task automatic flush_model();
      for (int d = 0; d < 2; d++) begin
         expq[d].delete();
         mcnt[d]        = '0;
         pop_pend[d]    = 1'b0;
         popped_prev[d] = 1'b0;
         prev_stall[d]  = 1'b0;
         prev_beat[d]   = '0;
         in_gap[d]      = 1'b0;
         gap_ok[d]      = 1'b0;
         gap_len[d]     = 0;
      end
   endtask

   // ---------------------------------------------------------------- monitor
   task automatic monitor_dut(input int d);
      beat_t act;
      logic  hs;
      act.data = tdata_w[d];
      act.keep = tkeep_w[d];
      act.last = tlast[d];
      hs       = tvalid[d] && tready[d];

      check(nm(d, "frame_count"), 128'(fcnt[d]), 128'(mcnt[d]));
      if (popped_prev[d]) check(nm(d, "tvalid_after_pop"), 128'(tvalid[d]), 128'(1'b1));
      if (prev_stall[d]) begin
         check(nm(d, "stall_tvalid"), 128'(tvalid[d]), 128'(1'b1));
         check(nm(d, "stall_beat"), 128'(act), 128'(prev_beat[d]));
      end
      if (!busy[d]) check(nm(d, "rd_enable_idle"), 128'(fifo_rd_enable[d]), 128'(1'b1));
      if (tvalid[d] && !(hs && tlast[d] && ifg(d) == 0))
         check(nm(d, "rd_enable_send"), 128'(fifo_rd_enable[d]), 128'(1'b0));

      if (in_gap[d]) begin
         if (!tvalid[d]) begin
            gap_len[d]++;
            if (!fifo_rd_valid[d]) gap_ok[d] = 1'b0;
         end else begin
            if (gap_ok[d]) check(nm(d, "ifg_cycles"), 128'(gap_len[d]), 128'(ifg(d)));
            in_gap[d] = 1'b0;
         end
      end

      if (tvalid[d]) begin
         check(nm(d, "busy_when_valid"), 128'(busy[d]), 128'(1'b1));
         check(nm(d, "beat_expected"), 128'(expq[d].size() > 0), 128'(1'b1));
         if (expq[d].size() > 0) begin
            check(nm(d, "tdata"), act.data, expq[d][0].data);
            check(nm(d, "tkeep"), 128'(act.keep), 128'(expq[d][0].keep));
            check(nm(d, "tlast"), 128'(act.last), 128'(expq[d][0].last));
            if (hs) expq[d].delete(0);
         end
         if (hs && tlast[d]) begin
            mcnt[d]    = mcnt[d] + 32'd1;
            in_gap[d]  = 1'b1;
            gap_len[d] = 0;
            gap_ok[d]  = fifo_rd_valid[d];
         end
      end

      popped_prev[d] = 1'b0;
      if (fifo_rd_valid[d] && fifo_rd_enable[d]) begin
         expect_frame(d, cmdq[d][0]);
         pop_pend[d]    = 1'b1;
         popped_prev[d] = 1'b1;
      end
      prev_stall[d] = tvalid[d] && !tready[d];
      prev_beat[d]  = act;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         monitor_dut(0);
         monitor_dut(1);
      end
   end

   // ---------------------------------------------------------------- driver
   initial begin : driver
      fifo_rd_valid = '0;
      tready        = '0;
      size_i        = '0;
      d_mac_i       = '0;
      s_mac_i       = '0;
      et_i          = '0;
      pl_i          = '0;
      mode_i        = '0;
      flush_model();
      forever begin
         @(posedge clk);
         #1;
         for (int d = 0; d < 2; d++) begin
            if (pop_pend[d]) begin
               cmdq[d].delete(0);
               pop_pend[d] = 1'b0;
            end
            if (cmdq[d].size() > 0 && (!valid_gaps || $urandom_range(3) != 0)) begin
               fifo_rd_valid[d] = 1'b1;
               size_i[d]        = cmdq[d][0].size;
               d_mac_i[d]       = cmdq[d][0].d_mac;
               s_mac_i[d]       = cmdq[d][0].s_mac;
               et_i[d]          = cmdq[d][0].et;
               pl_i[d]          = cmdq[d][0].seed;
               mode_i[d]        = cmdq[d][0].mode;
            end else begin
               // Junk on an invalid head must never reach a frame in flight.
               fifo_rd_valid[d] = 1'b0;
               size_i[d]        = 11'($urandom);
               d_mac_i[d]       = {16'($urandom), $urandom};
               s_mac_i[d]       = {16'($urandom), $urandom};
               et_i[d]          = 16'($urandom);
               pl_i[d]          = 8'($urandom);
               mode_i[d]        = 1'($urandom);
            end
            case (tr_mode)
               0:       tready[d] = 1'b1;
               1:       tready[d] = (tr_phase[d] % 4 == 0) || (tr_phase[d] % 4 == 3);
               default: tready[d] = ($urandom_range(9) < 7);
            endcase
            tr_phase[d]++;
         end
      end
   end

   // ---------------------------------------------------------------- sequence
   task automatic push_both(input cmd_t c);
      cmdq[0].push_back(c);
      cmdq[1].push_back(c);
   endtask

   task automatic drain(input string tag, input int budget);
      int n;
      n = 0;
      while ((cmdq[0].size() > 0 || cmdq[1].size() > 0 || expq[0].size() > 0 ||
              expq[1].size() > 0 || busy != 2'b00) && n < budget) begin
         @(posedge clk);
         n++;
      end
      check({tag, ".drain_in_budget"}, 128'(n < budget), 128'(1'b1));
      repeat (2) @(posedge clk);
   endtask

   task automatic pin_model();
      cmd_t  c;
      beat_t e;
      c = mk_cmd(11'd14, 8'h00, 1'b0);
      e = model_beat(c, 8, 0);
      check("model.hdr_beat0", e.data, 128'hEEFF112233445566);
      check("model.hdr_keep0", 128'(e.keep), 128'h00FF);
      e = model_beat(c, 8, 1);
      check("model.hdr_beat1", e.data, 128'h00000800AABBCCDD);
      check("model.hdr_keep1", 128'({e.keep, e.last}), 128'({16'h003F, 1'b1}));
      c = mk_cmd(11'd20, 8'hFE, 1'b1);
      e = model_beat(c, 8, 1);
      check("model.inc_beat1", e.data, 128'hFFFE0800AABBCCDD);
      e = model_beat(c, 8, 2);
      check("model.inc_beat2", e.data, 128'h03020100);
      check("model.inc_keep2", 128'({e.keep, e.last}), 128'({16'h000F, 1'b1}));
      c = mk_cmd(11'd60, 8'hA5, 1'b0);
      e = model_beat(c, 16, 0);
      check("model.fill_beat0", e.data, 128'hA5A50800AABBCCDDEEFF112233445566);
      e = model_beat(c, 16, 3);
      check("model.fill_keep3", 128'({e.keep, e.last}), 128'({16'h0FFF, 1'b1}));
      c = mk_cmd(11'd5, 8'h00, 1'b0);
      e = model_beat(c, 8, 1);
      check("model.pad_keep1", 128'({e.keep, e.last}), 128'({16'h003F, 1'b1}));
   endtask

   initial begin : main
      int n;
      pin_model();

      // Reset values while rst is still asserted.
      repeat (3) @(posedge clk);
      #3;
      for (int d = 0; d < 2; d++) begin
         check(nm(d, "rst_tvalid"), 128'(tvalid[d]), 128'(1'b0));
         check(nm(d, "rst_tlast"), 128'(tlast[d]), 128'(1'b0));
         check(nm(d, "rst_tdata"), tdata_w[d], 128'h0);
         check(nm(d, "rst_tkeep"), 128'(tkeep_w[d]), 128'h0);
         check(nm(d, "rst_frame_count"), 128'(fcnt[d]), 128'h0);
         check(nm(d, "rst_rd_enable"), 128'(fifo_rd_enable[d]), 128'(1'b0));
         check(nm(d, "rst_busy"), 128'(busy[d]), 128'(1'b0));
      end
      rst = 1'b0;

      // Directed frames, always ready: header spill, fill, increment wrap, padding.
      tr_mode = 0;
      push_both(mk_cmd(11'd14, 8'h00, 1'b0));
      push_both(mk_cmd(11'd60, 8'hA5, 1'b0));
      push_both(mk_cmd(11'd20, 8'hFE, 1'b1));
      push_both(mk_cmd(11'd5, 8'h3C, 1'b1));
      drain("directed", 400);

      // Stall pattern 1,0,0,1 over a 40-byte frame (5 beats at 64 bits).
      tr_mode = 1;
      push_both(mk_cmd(11'd40, 8'h77, 1'b1));
      drain("stall", 400);

      // Random commands, random backpressure and FIFO bubbles.
      tr_mode    = 2;
      valid_gaps = 1'b1;
      for (int i = 0; i < 30; i++) begin
         cmdq[0].push_back(rand_cmd());
         cmdq[1].push_back(rand_cmd());
      end
      drain("random", 40000);
      check("w64.count_after_random", 128'(fcnt[0]), 128'd35);
      check("w128.count_after_random", 128'(fcnt[1]), 128'd35);

      // Reset in the middle of a long frame, then a clean restart.
      tr_mode    = 0;
      valid_gaps = 1'b0;
      push_both(mk_cmd(11'd300, 8'h10, 1'b1));
      n = 0;
      while (!tvalid[0] && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("rst.frame_started", 128'(tvalid[0]), 128'(1'b1));
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) begin
         check(nm(d, "midrst_tvalid"), 128'(tvalid[d]), 128'(1'b0));
         check(nm(d, "midrst_tlast"), 128'(tlast[d]), 128'(1'b0));
         check(nm(d, "midrst_frame_count"), 128'(fcnt[d]), 128'h0);
         check(nm(d, "midrst_rd_enable"), 128'(fifo_rd_enable[d]), 128'(1'b0));
      end
      flush_model();
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b0;
      push_both(mk_cmd(11'd14, 8'h00, 1'b0));
      drain("restart", 400);
      check("w64.count_after_restart", 128'(fcnt[0]), 128'd1);
      check("w128.count_after_restart", 128'(fcnt[1]), 128'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
